// File: rtl/note_tone_bank.sv
// note_tone_bank: note index (1..88) per channel -> NCO square tones + mix.
// Octave-table converter FSM feeds per-channel phase accumulators.
// Ports: clk, rst_n (async low); wr_valid/wr_ready/wr_ch/wr_note write,
//   wr_err reject pulse; sq_out per-channel tone; mix_out high count;
//   busy converter active.
// Option: define GLIDE_EN for ticked increment glide toward target.
module note_tone_bank #(
  parameter int CH         = 4,
  parameter int ACC_W      = 32,
  parameter int INC_K      = 7205759,
  parameter int GLIDE_STEP = 64,
  parameter int GLIDE_DIV  = 1000,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1,
  localparam int MW = $clog2(CH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] wr_ch,
  input  logic [7:0]    wr_note,
  output logic          wr_err,
  output logic [CH-1:0] sq_out,
  output logic [MW-1:0] mix_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE, DIV, MUL, COMMIT
  } state_t;

  localparam logic [31:0] CHU = 32'(CH);

  state_t           state;
  logic [CW-1:0]    ch_q;
  logic [6:0]       rem;
  logic [2:0]       oct;
  logic [ACC_W-1:0] tgt_q;
  logic [19:0]      bv;
  logic [19:0]      freq;
  logic             bad;
  logic [CH-1:0]    hit;
  logic [MW-1:0]    pop;

  logic [ACC_W-1:0] acc [CH];
  logic [ACC_W-1:0] inc [CH];

  function automatic logic [19:0] base(
    input logic [3:0] i
  );
    case (i)
      4'd0:    base = 20'd176000;
      4'd1:    base = 20'd186466;
      4'd2:    base = 20'd197553;
      4'd3:    base = 20'd209301;
      4'd4:    base = 20'd221746;
      4'd5:    base = 20'd234932;
      4'd6:    base = 20'd248902;
      4'd7:    base = 20'd263702;
      4'd8:    base = 20'd279383;
      4'd9:    base = 20'd295996;
      4'd10:   base = 20'd313596;
      4'd11:   base = 20'd332244;
      default: base = 20'd0;
    endcase
  endfunction

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign bad = (wr_note > 8'd88)
             || (32'(wr_ch) >= CHU);

  always_comb begin
    bv   = base(rem[3:0]);
    freq = (oct <= 3'd6) ? (bv >> (3'd6 - oct))
                         : (bv << 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch_q   <= '0;
      rem    <= '0;
      oct    <= '0;
      tgt_q  <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_valid) begin
            if (bad) begin
              wr_err <= 1'b1;
            end else if (wr_note == 8'd0) begin
              ch_q  <= wr_ch;
              tgt_q <= '0;
              state <= COMMIT;
            end else begin
              ch_q  <= wr_ch;
              rem   <= 7'(wr_note - 8'd1);
              oct   <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (rem >= 7'd12) begin
            rem <= rem - 7'd12;
            oct <= oct + 3'd1;
          end else begin
            state <= MUL;
          end
        end
        MUL: begin
          // Only the bits above the 2^24 scale are kept.
          tgt_q <= ACC_W'((64'(freq) * 64'(INC_K)) >> 24);
          state <= COMMIT;
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      hit[c] = (state == COMMIT) && (ch_q == CW'(c));
    end
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < CH; c++) begin
      pop = pop + MW'(sq_out[c]);
    end
  end

`ifdef GLIDE_EN
  logic [ACC_W-1:0] target [CH];
  logic [ACC_W-1:0] gnxt   [CH];
  logic [31:0]      gcnt;
  logic             tick;
  logic [ACC_W-1:0] d;

  assign tick = (gcnt == 32'(GLIDE_DIV - 1));

  always_comb begin
    d = '0;
    for (int c = 0; c < CH; c++) begin
      gnxt[c] = inc[c];
      if (target[c] > inc[c]) begin
        d = target[c] - inc[c];
        gnxt[c] = inc[c] + ((d < ACC_W'(GLIDE_STEP))
                  ? d : ACC_W'(GLIDE_STEP));
      end else if (target[c] < inc[c]) begin
        d = inc[c] - target[c];
        gnxt[c] = inc[c] - ((d < ACC_W'(GLIDE_STEP))
                  ? d : ACC_W'(GLIDE_STEP));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
    end else begin
      gcnt <= tick ? '0 : gcnt + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        acc[c] <= '0;
        inc[c] <= '0;
`ifdef GLIDE_EN
        target[c] <= '0;
`endif
      end
      sq_out  <= '0;
      mix_out <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        // A rest restarts the phase; other rewrites keep it.
        acc[c] <= (hit[c] && tgt_q == '0) ? '0
                : acc[c] + inc[c];
`ifdef GLIDE_EN
        if (hit[c]) begin
          target[c] <= tgt_q;
          if (tgt_q == '0 || inc[c] == '0) begin
            inc[c] <= tgt_q;
          end
        end else if (tick) begin
          inc[c] <= gnxt[c];
        end
`else
        if (hit[c]) begin
          inc[c] <= tgt_q;
        end
`endif
        sq_out[c] <= acc[c][ACC_W-1] && (inc[c] != '0);
      end
      mix_out <= pop;
    end
  end

endmodule
